// File: rtl/sync_pulse_rx.sv
// Receiver side of a 4-phase req/ack handshake: one pulse per request, clk_b domain only.
// Optional saturating pulse counter enabled by defining SYNC_PULSE_RX_CNT_EN.
module sync_pulse_rx #(
    parameter int DLY         = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_b,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             rdy_b,
    output logic             pls_b,
    output logic             ack_b,
    output logic             busy_b,
    output logic             err_b,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic [1:0] {IDLE, WAIT_RDY, ACK} state_e;

    // Registers update with zero delay here; DLY is kept so existing instantiations still bind.
    logic unused_dly;
    assign unused_dly = (DLY != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_e                 state_q, state_d;
    logic                   pls_q, pls_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], req_a};
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pls_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pls_q   <= pls_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pls_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (rdy_b) begin
                        pls_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                // Withdrawal wins over a simultaneous rdy_b.
                if (!req_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (rdy_b) begin
                    pls_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (req_s) ack_d   = 1'b1;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pls_b  = pls_q;
    assign ack_b  = ack_q;
    assign err_b  = err_q;
    assign busy_b = (state_q != IDLE);

`ifdef SYNC_PULSE_RX_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pls_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_b = cnt_q;
`else
    assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_sync_pulse_rx.sv
// Self-checking bench for sync_pulse_rx; a second instance with CNT_W=2 covers counter saturation.
module tb_sync_pulse_rx;
    localparam int SS = 2;
`ifdef SYNC_PULSE_RX_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk_b = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_a = 1'b0;
    logic       rdy_b = 1'b0;
    logic       pls_b, ack_b, busy_b, err_b;
    logic [7:0] cnt_b;
    logic       pls2, ack2, busy2, err2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;
    int npls   = 0;
    int nerr   = 0;

    sync_pulse_rx #(.DLY(1), .SYNC_STAGES(SS), .CNT_W(8)) dut (
        .clk_b(clk_b), .rst_n(rst_n), .req_a(req_a), .rdy_b(rdy_b),
        .pls_b(pls_b), .ack_b(ack_b), .busy_b(busy_b), .err_b(err_b), .cnt_b(cnt_b)
    );

    sync_pulse_rx #(.DLY(1), .SYNC_STAGES(SS), .CNT_W(2)) dut_sat (
        .clk_b(clk_b), .rst_n(rst_n), .req_a(req_a), .rdy_b(rdy_b),
        .pls_b(pls2), .ack_b(ack2), .busy_b(busy2), .err_b(err2), .cnt_b(cnt2)
    );

    always #5 clk_b = ~clk_b;

    always @(negedge clk_b) begin
        if (rst_n) begin
            if (pls_b) npls++;
            if (err_b) nerr++;
        end
    end

    // Expected counter value after n delivered pulses on a w-bit counter.
    function automatic int exp_cnt(int n, int w);
        int sat;
        sat = (1 << w) - 1;
        return CNT_ON ? ((n > sat) ? sat : n) : 0;
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk_b);
            #1;
        end
    endtask

    task automatic apply_reset();
        req_a = 1'b0;
        rdy_b = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick(2);
        checks++; if (pls_b !== 1'b0)  begin errors++; $display("FAIL reset_pls: got %b expected 0", pls_b); end
        checks++; if (ack_b !== 1'b0)  begin errors++; $display("FAIL reset_ack: got %b expected 0", ack_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_b); end
        checks++; if (err_b !== 1'b0)  begin errors++; $display("FAIL reset_err: got %b expected 0", err_b); end
        checks++; if (cnt_b !== 8'd0)  begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt_b); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        logic exp;
        rdy_b = 1'b1;
        req_a = 1'b1;
        for (int e = 1; e <= SS + 1; e++) begin
            tick();
            exp = (e == SS + 1);
            checks++;
            if (pls_b !== exp || ack_b !== exp) begin
                errors++; $display("FAIL basic_rise edge %0d: pls=%b ack=%b expected %b", e, pls_b, ack_b, exp);
            end
        end
        tick();
        checks++;
        if (pls_b !== 1'b0 || ack_b !== 1'b1) begin
            errors++; $display("FAIL basic_width: pls=%b ack=%b expected pls=0 ack=1", pls_b, ack_b);
        end
        checks++;
        if (cnt_b !== 8'(exp_cnt(1, 8))) begin
            errors++; $display("FAIL basic_cnt: got %0d expected %0d", cnt_b, exp_cnt(1, 8));
        end
        req_a = 1'b0;
        for (int e = 1; e <= SS + 1; e++) begin
            tick();
            exp = (e < SS + 1);
            checks++;
            if (ack_b !== exp || busy_b !== exp) begin
                errors++; $display("FAIL basic_fall edge %0d: ack=%b busy=%b expected %b", e, ack_b, busy_b, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        rdy_b = 1'b0;
        req_a = 1'b1;
        tick(SS + 1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy_b !== 1'b1 || pls_b !== 1'b0 || ack_b !== 1'b0) begin
                errors++; $display("FAIL bp_hold cycle %0d: busy=%b pls=%b ack=%b expected 1 0 0", i, busy_b, pls_b, ack_b);
            end
            tick();
        end
        rdy_b = 1'b1;
        tick();
        checks++;
        if (pls_b !== 1'b1 || ack_b !== 1'b1) begin
            errors++; $display("FAIL bp_release: pls=%b ack=%b expected 1 1", pls_b, ack_b);
        end
        tick();
        checks++;
        if (pls_b !== 1'b0) begin errors++; $display("FAIL bp_width: pls=%b expected 0", pls_b); end
        req_a = 1'b0;
        tick(SS + 1);
        checks++;
        if (ack_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL bp_done: ack=%b busy=%b expected 0 0", ack_b, busy_b);
        end
    endtask

    task automatic test_withdraw();
        int p0, e0;
        rdy_b = 1'b0;
        req_a = 1'b1;
        tick(SS + 4);
        p0 = npls;
        e0 = nerr;
        req_a = 1'b0;
        for (int e = 1; e <= SS + 2; e++) begin
            tick();
            checks++;
            if (err_b !== (e == SS + 1) || pls_b !== 1'b0 || ack_b !== 1'b0) begin
                errors++; $display("FAIL wd_edge %0d: err=%b pls=%b ack=%b expected err=%b", e, err_b, pls_b, ack_b, (e == SS + 1));
            end
        end
        checks++;
        if (busy_b !== 1'b0) begin errors++; $display("FAIL wd_idle: busy=%b expected 0", busy_b); end
        checks++;
        if (nerr - e0 != 1 || npls - p0 != 0) begin
            errors++; $display("FAIL wd_counts: err pulses %0d pls pulses %0d expected 1 0", nerr - e0, npls - p0);
        end
    endtask

    task automatic test_back_to_back();
        int p0, e0, n;
        bit served;
        logic exp;
        apply_reset();
        p0 = npls;
        e0 = nerr;
        for (int h = 0; h < 50; h++) begin
            req_a  = 1'b1;
            n      = 0;
            served = 1'b0;
            // Pulse is due at the first edge from SS+1 onward that samples rdy_b high.
            while (!served && n < 100) begin
                rdy_b = 1'($urandom_range(0, 1));
                tick();
                n++;
                exp = (n >= SS + 1) && rdy_b;
                checks++;
                if (pls_b !== exp || ack_b !== exp) begin
                    errors++; $display("FAIL b2b_pulse hs %0d edge %0d: pls=%b ack=%b expected %b", h, n, pls_b, ack_b, exp);
                end
                if (exp) served = 1'b1;
            end
            checks++;
            if (!served) begin errors++; $display("FAIL b2b_timeout hs %0d: no pulse within 100 cycles", h); end
            req_a = 1'b0;
            for (int e = 1; e <= SS + 1; e++) begin
                rdy_b = 1'($urandom_range(0, 1));
                tick();
                checks++;
                if (ack_b !== (e < SS + 1) || pls_b !== 1'b0) begin
                    errors++; $display("FAIL b2b_fall hs %0d edge %0d: ack=%b pls=%b expected ack=%b", h, e, ack_b, pls_b, (e < SS + 1));
                end
            end
        end
        checks++;
        if (npls - p0 != 50) begin errors++; $display("FAIL b2b_npls: got %0d expected 50", npls - p0); end
        checks++;
        if (nerr - e0 != 0) begin errors++; $display("FAIL b2b_nerr: got %0d expected 0", nerr - e0); end
        checks++;
        if (cnt_b !== 8'(exp_cnt(50, 8))) begin
            errors++; $display("FAIL b2b_cnt: got %0d expected %0d", cnt_b, exp_cnt(50, 8));
        end
    endtask

    task automatic test_reset_mid_ack();
        int p0;
        apply_reset();
        rdy_b = 1'b1;
        req_a = 1'b1;
        tick(SS + 3);
        checks++;
        if (ack_b !== 1'b1) begin errors++; $display("FAIL rma_pre: ack=%b expected 1", ack_b); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pls_b !== 1'b0 || ack_b !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0 || cnt_b !== 8'd0) begin
            errors++; $display("FAIL rma_clear: pls=%b ack=%b busy=%b err=%b cnt=%0d expected all 0", pls_b, ack_b, busy_b, err_b, cnt_b);
        end
        tick(2);
        rst_n = 1'b1;
        p0 = npls;
        for (int e = 1; e <= SS + 2; e++) begin
            tick();
            checks++;
            if (pls_b !== (e == SS + 1) || ack_b !== (e >= SS + 1)) begin
                errors++; $display("FAIL rma_new edge %0d: pls=%b ack=%b expected pls=%b ack=%b", e, pls_b, ack_b, (e == SS + 1), (e >= SS + 1));
            end
        end
        checks++;
        if (npls - p0 != 1) begin errors++; $display("FAIL rma_npls: got %0d expected 1", npls - p0); end
        req_a = 1'b0;
        tick(SS + 2);
        checks++;
        if (ack_b !== 1'b0 || cnt_b !== 8'(exp_cnt(1, 8))) begin
            errors++; $display("FAIL rma_end: ack=%b cnt=%0d expected ack=0 cnt=%0d", ack_b, cnt_b, exp_cnt(1, 8));
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            rdy_b = 1'b1;
            req_a = 1'b1;
            tick(SS + 2);
            checks++;
            if (cnt2 !== 2'(exp_cnt(i, 2))) begin
                errors++; $display("FAIL sat_cnt hs %0d: got %0d expected %0d", i, cnt2, exp_cnt(i, 2));
            end
            req_a = 1'b0;
            tick(SS + 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_withdraw();
        test_back_to_back();
        test_reset_mid_ack();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
